// File: rtl/svm_linear_classifier_if.sv
// Handshake and configuration bundle between the feature extractor/host and the linear-SVM classifier.
// The master drives requests and coefficient writes; the slave (classifier) returns status and results.
interface svm_linear_classifier_if #(
  parameter int N_FEAT  = 7,
  parameter int FEAT_W  = 16,
  parameter int COEF_W  = 16,
  parameter int SCORE_W = 24
);
  localparam int ADDR_W = $clog2(N_FEAT + 1);

  logic                       start;
  logic [N_FEAT*FEAT_W-1:0]   feature_vec;
  logic                       cfg_we;
  logic [ADDR_W-1:0]          cfg_addr;
  logic [COEF_W-1:0]          cfg_wdata;
  logic                       alarm_clr;
  logic                       busy;
  logic                       done;
  logic [SCORE_W-1:0]         score;
  logic                       fall_detected;
  logic                       fall_alarm;

  modport master (
    output start, feature_vec, cfg_we, cfg_addr, cfg_wdata, alarm_clr,
    input  busy, done, score, fall_detected, fall_alarm
  );

  modport slave (
    input  start, feature_vec, cfg_we, cfg_addr, cfg_wdata, alarm_clr,
    output busy, done, score, fall_detected, fall_alarm
  );
endinterface

// File: rtl/svm_linear_classifier.sv
// Sequential linear-SVM classifier: one MAC per cycle over N_FEAT features, bias add, saturated score,
// per-window fall decision and a consecutive-window confirmation counter driving fall_alarm.
module svm_linear_classifier #(
  parameter int N_FEAT    = 7,
  parameter int FEAT_W    = 16,
  parameter int COEF_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40,
  parameter int SCORE_W   = 24,
  parameter int CONFIRM_N = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  svm_linear_classifier_if.slave   bus
);
  localparam int ADDR_W = $clog2(N_FEAT + 1);
  localparam int PROD_W = FEAT_W + COEF_W;
  localparam int CNT_W  = $clog2(CONFIRM_N + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_FEAT - 1);
  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(N_FEAT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CONFIRM_N);
  localparam logic signed [ACC_W-1:0] SCORE_MAX = {{(ACC_W-SCORE_W+1){1'b0}}, {(SCORE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SCORE_MIN = {{(ACC_W-SCORE_W+1){1'b1}}, {(SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, BIAS, DONE} state_t;

  state_t                     state;
  logic signed [COEF_W-1:0]   weight [N_FEAT];
  logic signed [COEF_W-1:0]   bias;
  logic [N_FEAT*FEAT_W-1:0]   feat;
  logic signed [ACC_W-1:0]    acc;
  logic [ADDR_W-1:0]          idx;
  logic [CNT_W-1:0]           cnt;

  logic signed [FEAT_W-1:0]   f_cur;
  logic signed [COEF_W-1:0]   w_cur;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    acc_mac;
  logic signed [ACC_W-1:0]    acc_bias;
  logic signed [ACC_W-1:0]    shifted;
  logic [SCORE_W-1:0]         score_sat;
  logic [CNT_W-1:0]           cnt_next;

  always_comb begin
    f_cur = '0;
    w_cur = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (idx == ADDR_W'(i)) begin
        f_cur = feat[i*FEAT_W +: FEAT_W];
        w_cur = weight[i];
      end
    end
    prod     = f_cur * w_cur;
    acc_mac  = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    // Bias is Q(FRAC_BITS); align it to the Q(2*FRAC_BITS) accumulator before adding.
    acc_bias = acc + {{(ACC_W-COEF_W-FRAC_BITS){bias[COEF_W-1]}}, bias, {FRAC_BITS{1'b0}}};
    shifted  = acc_bias >>> FRAC_BITS;
    if (shifted > SCORE_MAX)
      score_sat = SCORE_MAX[SCORE_W-1:0];
    else if (shifted < SCORE_MIN)
      score_sat = SCORE_MIN[SCORE_W-1:0];
    else
      score_sat = shifted[SCORE_W-1:0];
    if (acc_bias[ACC_W-1])
      cnt_next = '0;
    else if (cnt == CNT_MAX)
      cnt_next = CNT_MAX;
    else
      cnt_next = cnt + CNT_W'(1);
  end

  // Coefficients are only writable while idle so a run never sees a half-updated model.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_FEAT; i++) weight[i] <= '0;
      bias <= '0;
    end else if (state == IDLE && bus.cfg_we) begin
      if (bus.cfg_addr < BIAS_ADDR)
        weight[bus.cfg_addr] <= bus.cfg_wdata;
      else if (bus.cfg_addr == BIAS_ADDR)
        bias <= bus.cfg_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      feat              <= '0;
      acc               <= '0;
      idx               <= '0;
      cnt               <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.score         <= '0;
      bus.fall_detected <= 1'b0;
      bus.fall_alarm    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            feat     <= bus.feature_vec;
            acc      <= '0;
            idx      <= '0;
            bus.busy <= 1'b1;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc_mac;
          if (idx == LAST_IDX)
            state <= BIAS;
          else
            idx <= idx + ADDR_W'(1);
        end
        BIAS: begin
          // Results are registered here so they appear together with the done pulse.
          acc               <= acc_bias;
          bus.score         <= score_sat;
          bus.fall_detected <= ~acc_bias[ACC_W-1];
          cnt               <= cnt_next;
          bus.fall_alarm    <= (cnt_next == CNT_MAX);
          bus.done          <= 1'b1;
          bus.busy          <= 1'b0;
          state             <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (bus.alarm_clr) begin
        cnt            <= '0;
        bus.fall_alarm <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_svm_linear_classifier.sv
// Directed, table-driven bench for svm_linear_classifier with hand-computed expected scores,
// plus hand-written sequences for ignored requests, alarm clearing and mid-run reset.
module tb_svm_linear_classifier;
  localparam int N_FEAT    = 7;
  localparam int FEAT_W    = 16;
  localparam int COEF_W    = 16;
  localparam int FRAC_BITS = 8;
  localparam int ACC_W     = 40;
  localparam int SCORE_W   = 24;
  localparam int CONFIRM_N = 3;
  localparam int LATENCY   = N_FEAT + 2;
  localparam int TIMEOUT   = 50;

  typedef struct {
    logic [COEF_W-1:0]  w;
    logic [COEF_W-1:0]  b;
    logic [FEAT_W-1:0]  f;
    logic [SCORE_W-1:0] score;
    logic               fd;
    logic               alarm;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   failures = 0;

  svm_linear_classifier_if #(.N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .COEF_W(COEF_W), .SCORE_W(SCORE_W)) bus ();

  svm_linear_classifier #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .COEF_W(COEF_W), .FRAC_BITS(FRAC_BITS),
    .ACC_W(ACC_W), .SCORE_W(SCORE_W), .CONFIRM_N(CONFIRM_N)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic writeCoef(input int addr, input logic [COEF_W-1:0] data);
    @(negedge clk);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'(addr);
    bus.cfg_wdata = data;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic setCoefs(input logic [COEF_W-1:0] w, input logic [COEF_W-1:0] b);
    for (int i = 0; i < N_FEAT; i++) writeCoef(i, w);
    writeCoef(N_FEAT, b);
  endtask

  // Called at the negedge right after the start-sampling edge; returns the edge count at done.
  task automatic waitDone(output int lat);
    lat = 1;
    while (!bus.done && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic runOnce(input logic [FEAT_W-1:0] f, output int lat);
    @(negedge clk);
    bus.feature_vec = {N_FEAT{f}};
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
    waitDone(lat);
  endtask

  task automatic applyStimulus(input vec_t v, output int lat);
    setCoefs(v.w, v.b);
    runOnce(v.f, lat);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs [8];
  int   lat;
  int   dones;

  initial begin
    // uniform weight / bias / feature cases; alarm column follows the running confirmation count
    vecs[0] = '{w:16'h0100, b:16'h0000, f:16'h0100, score:24'h000700, fd:1'b1, alarm:1'b0};
    vecs[1] = '{w:16'h0200, b:16'h0100, f:16'h0080, score:24'h000800, fd:1'b1, alarm:1'b0};
    vecs[2] = '{w:16'h7FFF, b:16'h0000, f:16'h7FFF, score:24'h7FFFFF, fd:1'b1, alarm:1'b1};
    vecs[3] = '{w:16'h0100, b:16'h0000, f:16'h0100, score:24'h000700, fd:1'b1, alarm:1'b1};
    vecs[4] = '{w:16'h0100, b:16'hF800, f:16'h0100, score:24'hFFFF00, fd:1'b0, alarm:1'b0};
    vecs[5] = '{w:16'hFF00, b:16'h0700, f:16'h0100, score:24'h000000, fd:1'b1, alarm:1'b0};
    vecs[6] = '{w:16'hFF00, b:16'h0000, f:16'h0001, score:24'hFFFFF9, fd:1'b0, alarm:1'b0};
    vecs[7] = '{w:16'h8000, b:16'h8000, f:16'h7FFF, score:24'h800000, fd:1'b0, alarm:1'b0};

    reset           = 1'b1;
    bus.start       = 1'b0;
    bus.feature_vec = '0;
    bus.cfg_we      = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_wdata   = '0;
    bus.alarm_clr   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset score", 32'(bus.score), 32'd0);
    checkOutput("reset fall_detected", 32'(bus.fall_detected), 32'd0);
    checkOutput("reset fall_alarm", 32'(bus.fall_alarm), 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(LATENCY));
      checkOutput($sformatf("v%0d score", i), 32'(bus.score), 32'(vecs[i].score));
      checkOutput($sformatf("v%0d fall_detected", i), 32'(bus.fall_detected), 32'(vecs[i].fd));
      checkOutput($sformatf("v%0d fall_alarm", i), 32'(bus.fall_alarm), 32'(vecs[i].alarm));
      @(negedge clk);
      checkOutput($sformatf("v%0d done one cycle", i), 32'(bus.done), 32'd0);
    end

    // start and cfg write during a run are both ignored
    doReset();
    setCoefs(16'h0100, 16'h0000);
    @(negedge clk);
    bus.feature_vec = {N_FEAT{16'h0100}};
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start       = 1'b0;
    checkOutput("busy at T+1", 32'(bus.busy), 32'd1);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'd0;
    bus.cfg_wdata = 16'h0000;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) dones++;
      @(negedge clk);
    end
    checkOutput("ignored start single done", 32'(dones), 32'd1);
    checkOutput("ignored start score", 32'(bus.score), 32'h000700);
    runOnce(16'h0100, lat);
    checkOutput("busy cfg write dropped", 32'(bus.score), 32'h000700);

    // alarm_clr restarts the confirmation count
    doReset();
    setCoefs(16'h0100, 16'h0000);
    runOnce(16'h0100, lat);
    runOnce(16'h0100, lat);
    checkOutput("alarm after 2 runs", 32'(bus.fall_alarm), 32'd0);
    @(negedge clk);
    bus.alarm_clr = 1'b1;
    @(negedge clk);
    bus.alarm_clr = 1'b0;
    runOnce(16'h0100, lat);
    checkOutput("alarm after clr+1", 32'(bus.fall_alarm), 32'd0);
    runOnce(16'h0100, lat);
    checkOutput("alarm after clr+2", 32'(bus.fall_alarm), 32'd0);
    runOnce(16'h0100, lat);
    checkOutput("alarm after clr+3", 32'(bus.fall_alarm), 32'd1);
    @(negedge clk);
    bus.alarm_clr = 1'b1;
    @(negedge clk);
    bus.alarm_clr = 1'b0;
    checkOutput("alarm cleared", 32'(bus.fall_alarm), 32'd0);

    // coefficient write in the start cycle is used by that run
    setCoefs(16'h0100, 16'h0000);
    @(negedge clk);
    bus.feature_vec = {N_FEAT{16'h0100}};
    bus.start       = 1'b1;
    bus.cfg_we      = 1'b1;
    bus.cfg_addr    = 3'(N_FEAT);
    bus.cfg_wdata   = 16'h0100;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    waitDone(lat);
    checkOutput("start-cycle write latency", 32'(lat), 32'(LATENCY));
    checkOutput("start-cycle write score", 32'(bus.score), 32'h000800);

    // reset mid-run aborts and zeroes the coefficients
    setCoefs(16'h0100, 16'h0000);
    @(negedge clk);
    bus.feature_vec = {N_FEAT{16'h0100}};
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("mid-run reset busy", 32'(bus.busy), 32'd0);
    checkOutput("mid-run reset done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    checkOutput("no done after abort", 32'(dones), 32'd0);
    runOnce(16'h0100, lat);
    checkOutput("post-reset latency", 32'(lat), 32'(LATENCY));
    checkOutput("post-reset score", 32'(bus.score), 32'h000000);
    checkOutput("post-reset fall_detected", 32'(bus.fall_detected), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
